// File: rtl/mdu_seq_pkg.sv
// Shared op constants for the execute stage: ALU ops, M-extension encodings and
// the multiply/divide unit state encoding.
package mdu_seq_pkg;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSlt, AluSltu, AluSll, AluSrl, AluSra
  } alu_op_e;

  localparam logic [6:0] Funct7M = 7'b0000001;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} mdu_state_e;

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface mdu_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            iflush;
  logic            ivalid;
  logic [2:0]      ifunct3;
  logic [XLEN-1:0] isrca;
  logic [XLEN-1:0] isrcb;
  logic            oready;
  logic            obusy;
  logic            ovalid;
  logic [XLEN-1:0] oresult;

  modport master (
    output iflush, ivalid, ifunct3, isrca, isrcb,
    input  oready, obusy, ovalid, oresult
  );

  modport slave (
    input  iflush, ivalid, ifunct3, isrca, isrcb,
    output oready, obusy, ovalid, oresult
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one sign-fix cycle, single-cycle fast paths for divide-by-zero and signed overflow.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic         iclk,
  input logic         irst_n,
  mdu_seq_if.slave    bus
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0]   One    = XLEN'(1);
  localparam logic [2*XLEN-1:0] One2   = (2*XLEN)'(1);
  localparam logic [XLEN-1:0]   MinNeg = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]     Last   = CW'(XLEN - 1);

  mdu_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, quo_q, rem_q, result_q;
  logic [2*XLEN-1:0] prod_q;
  logic              neg_res_q, neg_rem_q;

  function automatic logic [XLEN-1:0] cneg(input logic c, input logic [XLEN-1:0] x);
    return c ? (~x + One) : x;
  endfunction

  logic            accept, a_neg, b_neg, div_zero, ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    accept   = bus.ivalid & (state_q == StIdle);
    a_neg    = (bus.ifunct3 inside {F3Mulh, F3Mulhsu, F3Div, F3Rem}) & bus.isrca[XLEN-1];
    b_neg    = (bus.ifunct3 inside {F3Mulh, F3Div, F3Rem}) & bus.isrcb[XLEN-1];
    a_mag    = cneg(a_neg, bus.isrca);
    b_mag    = cneg(b_neg, bus.isrcb);
    div_zero = bus.ifunct3[2] & (bus.isrcb == '0);
    ovf      = (bus.ifunct3 inside {F3Div, F3Rem}) & (bus.isrca == MinNeg) & (bus.isrcb == '1);
    fast     = div_zero | ovf;
    // funct3[1] separates REM* from DIV* among the divide ops
    if (div_zero) fast_res = bus.ifunct3[1] ? bus.isrca : '1;
    else          fast_res = bus.ifunct3[1] ? '0 : bus.isrca;
  end

  // One adder serves both loops: accumulate for multiply, trial subtract for divide.
  logic            is_div;
  logic [XLEN:0]   rem_shift, add_l, add_r, add_s;
  logic            quo_bit;

  always_comb begin
    is_div    = op_q[2];
    rem_shift = {rem_q, quo_q[XLEN-1]};
    add_l     = is_div ? rem_shift : {1'b0, prod_q[2*XLEN-1:XLEN]};
    add_r     = is_div ? ~{1'b0, b_q} : (prod_q[0] ? {1'b0, a_q} : '0);
    add_s     = add_l + add_r + {{XLEN{1'b0}}, is_div};
    quo_bit   = ~add_s[XLEN];
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_res_q ? (~prod_q + One2) : prod_q;
    fix_res  = '0;
    case (op_q)
      F3Mul:                     fix_res = prod_fix[XLEN-1:0];
      F3Mulh, F3Mulhsu, F3Mulhu: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3Div, F3Divu:             fix_res = cneg(neg_res_q, quo_q);
      default:                   fix_res = cneg(neg_rem_q, rem_q);
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (bus.iflush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q  <= bus.ifunct3;
            cnt_q <= '0;
            if (fast) begin
              result_q <= fast_res;
              state_q  <= StDone;
            end else begin
              a_q       <= a_mag;
              b_q       <= b_mag;
              prod_q    <= {{XLEN{1'b0}}, b_mag};
              quo_q     <= a_mag;
              rem_q     <= '0;
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              state_q   <= StCalc;
            end
          end
        end
        StCalc: begin
          if (is_div) begin
            // A set top bit in rem_shift always subtracts, so dropping it is safe
            rem_q <= quo_bit ? add_s[XLEN-1:0] : rem_shift[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], quo_bit};
          end else begin
            prod_q <= {add_s, prod_q[XLEN-1:1]};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == Last) state_q <= StFix;
        end
        StFix: begin
          result_q <= fix_res;
          state_q  <= StDone;
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

  assign bus.oready  = (state_q == StIdle);
  assign bus.obusy   = (state_q != StIdle);
  assign bus.ovalid  = (state_q == StDone) & ~bus.iflush;
  assign bus.oresult = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed vectors push expected results, a monitor
// pops and compares on every ovalid; latency, handshake, flush and reset are timed.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_seq_if #(.XLEN(XLEN)) bus ();

  mdu_seq #(.XLEN(XLEN)) dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    string           name;
    logic [XLEN-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.ovalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected ovalid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, bus.oresult, e.val);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.oready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("oready timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    wait_ready();
    bus.ifunct3 = f3;
    bus.isrca   = a;
    bus.isrcb   = b;
    bus.ivalid  = 1'b1;
    @(posedge clk);
    #1 bus.ivalid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat,
                        output logic busy_all);
    int seen = 0;
    busy_all = 1'b1;
    exp_q.push_back('{name, exp});
    issue(f3, a, b);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      busy_all &= (bus.obusy === 1'b1);
      if (bus.ovalid === 1'b1) begin
        seen = k;
        break;
      end
    end
    check({name, " latency"}, 64'(seen), 64'(lat));
    @(negedge clk);
    check({name, " idle after"}, {bus.oready, bus.obusy, bus.ovalid}, 3'b100);
  endtask

  initial begin
    logic busy_all;
    int   first, second, nvalid;

    bus.iflush  = 1'b0;
    bus.ivalid  = 1'b0;
    bus.ifunct3 = '0;
    bus.isrca   = '0;
    bus.isrcb   = '0;
    repeat (2) @(negedge clk);
    check("reset oready", bus.oready, 1);
    check("reset obusy", bus.obusy, 0);
    check("reset ovalid", bus.ovalid, 0);
    check("reset oresult", bus.oresult, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("MUL 7*-3", F3Mul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, busy_all);
    check("MUL obusy cycles 1..34", busy_all, 1);
    run_op("MULH min*min", F3Mulh, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, busy_all);
    run_op("MULHU ff*ff", F3Mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, busy_all);
    run_op("MULHSU ff*ff", F3Mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, busy_all);
    run_op("MULH -1*5", F3Mulh, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 34, busy_all);
    run_op("DIV -7/2", F3Div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, busy_all);
    run_op("REM -7/2", F3Rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, busy_all);
    run_op("DIV 7/-2", F3Div, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, busy_all);
    run_op("DIVU 100/7", F3Divu, 32'd100, 32'd7, 32'd14, 34, busy_all);
    run_op("REMU 100/7", F3Remu, 32'd100, 32'd7, 32'd2, 34, busy_all);
    run_op("DIVU ff/1", F3Divu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, busy_all);
    run_op("DIVU 5/0", F3Divu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, busy_all);
    run_op("REM 5/0", F3Rem, 32'd5, 32'd0, 32'd5, 1, busy_all);
    run_op("DIV min/-1", F3Div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, busy_all);
    run_op("REM min/-1", F3Rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, busy_all);

    // ivalid held through the op with new operands mid-flight
    wait_ready();
    exp_q.push_back('{"hs first DIV 100/7", 32'd14});
    exp_q.push_back('{"hs second DIV 50/5", 32'd10});
    bus.ifunct3 = F3Div;
    bus.isrca   = 32'd100;
    bus.isrcb   = 32'd7;
    bus.ivalid  = 1'b1;
    @(posedge clk);
    #1;
    bus.isrca = 32'd50;
    bus.isrcb = 32'd5;
    first = 0;
    second = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 35) check("hs idle gap", {bus.oready, bus.obusy}, 2'b10);
      if (k == 36) bus.ivalid = 1'b0;
      if (bus.ovalid === 1'b1) begin
        if (first == 0) first = k;
        else begin
          second = k;
          break;
        end
      end
    end
    check("hs first latency", 64'(first), 64'd34);
    check("hs second latency", 64'(second), 64'd69);
    @(negedge clk);

    // Flush in CALC cycle 10: no result, oresult keeps 10
    issue(F3Mul, 32'd7, 32'd3);
    repeat (10) @(negedge clk);
    check("flush pre obusy", bus.obusy, 1);
    bus.iflush = 1'b1;
    @(posedge clk);
    #1 bus.iflush = 1'b0;
    @(negedge clk);
    check("flush idle", {bus.oready, bus.obusy, bus.ovalid}, 3'b100);
    check("flush oresult", bus.oresult, 32'd10);
    nvalid = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ovalid === 1'b1) nvalid++;
    end
    check("flush no ovalid", 64'(nvalid), 64'd0);

    // Flush coinciding with DONE suppresses the strobe
    issue(F3Divu, 32'd5, 32'd0);
    bus.iflush = 1'b1;
    @(negedge clk);
    check("flush in DONE ovalid", bus.ovalid, 0);
    @(posedge clk);
    #1 bus.iflush = 1'b0;
    @(negedge clk);
    check("flush in DONE idle", {bus.oready, bus.obusy, bus.ovalid}, 3'b100);

    // Async reset mid-CALC
    issue(F3Divu, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst oready", bus.oready, 1);
    check("rst obusy", bus.obusy, 0);
    check("rst ovalid", bus.ovalid, 0);
    check("rst oresult", bus.oresult, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("REMU 9/4 after rst", F3Remu, 32'd9, 32'd4, 32'd1, 34, busy_all);

    repeat (5) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
